// File: rtl/branch_resolve_pc_unit.sv
// ID-stage branch/jump resolution, fetch PC register and saturating branch counters.
// state | meaning
// BOOT  | first cycle after reset, fetch not yet valid, pc_if holds RESET_PC
// RUN   | normal fetch, branches resolve in ID
// TRAP  | misaligned target seen, squash IF/ID and vector to TRAP_VEC
module branch_resolve_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             id_valid,
  input  logic             id_branch,
  input  logic             id_jal,
  input  logic             id_jalr,
  input  logic [2:0]       id_funct3,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      id_imm,
  input  logic [31:0]      id_rs1_fwd,
  input  logic             BrEq,
  input  logic             BrLT,
  output logic             BrUn,
  output logic [31:0]      pc_if,
  output logic             fetch_valid,
  output logic             if_id_flush,
  output logic             misalign_exc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] br_taken_cnt
);

  typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic        cond, res, taken, misaligned;
  logic [31:0] target;
  logic        br_inc, tk_inc;

  assign BrUn = id_funct3[1];

  always_comb begin
    cond = 1'b0;
    case (id_funct3)
      3'b000:  cond = BrEq;
      3'b001:  cond = ~BrEq;
      3'b100:  cond = BrLT;
      3'b101:  cond = ~BrLT;
      3'b110:  cond = BrLT;
      3'b111:  cond = ~BrLT;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    res    = id_valid & ~stall & (state == RUN);
    taken  = res & (id_jalr | id_jal | (id_branch & cond));
    // jalr has priority over jal/branch when several type bits are set
    target = id_jalr ? ((id_rs1_fwd + id_imm) & ~32'h1) : (id_pc + id_imm);
    misaligned = |target[1:0];
    br_inc = res & id_branch;
    tk_inc = br_inc & taken;
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_if;
    fetch_valid  = 1'b0;
    if_id_flush  = 1'b0;
    misalign_exc = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      TRAP: begin
        if_id_flush = 1'b1;
        state_nxt   = RUN;
        pc_nxt      = TRAP_VEC;
      end
      RUN: begin
        fetch_valid = 1'b1;
        if (taken) begin
          if_id_flush = 1'b1;
          if (misaligned) begin
            misalign_exc = 1'b1;
            state_nxt    = TRAP;
          end else begin
            pc_nxt = target;
          end
        end else if (!stall) begin
          pc_nxt = pc_if + 32'd4;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc_if <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc_if <= pc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count     <= '0;
      br_taken_cnt <= '0;
    end else begin
      if (br_inc && (br_count != '1))
        br_count <= br_count + CNT_W'(1);
      if (tk_inc && (br_taken_cnt != '1))
        br_taken_cnt <= br_taken_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_pc_unit.sv
// Bench for branch_resolve_pc_unit: vector table, directed corner sequences, random vs model.
module tb_branch_resolve_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TVEC   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall, id_valid, id_branch, id_jal, id_jalr, BrEq, BrLT;
  logic [2:0]  id_funct3;
  logic [31:0] id_pc, id_imm, id_rs1_fwd;

  logic        BrUn, fetch_valid, if_id_flush, misalign_exc;
  logic [31:0] pc_if, br_count, br_taken_cnt;
  logic        BrUn_s, fetch_valid_s, if_id_flush_s, misalign_exc_s;
  logic [31:0] pc_if_s;
  logic [1:0]  br_count_s, br_taken_cnt_s;

  always #5 clk = ~clk;

  branch_resolve_pc_unit #(.RESET_PC(RST_PC), .TRAP_VEC(TVEC), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .id_valid(id_valid), .id_branch(id_branch),
    .id_jal(id_jal), .id_jalr(id_jalr), .id_funct3(id_funct3), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1_fwd(id_rs1_fwd), .BrEq(BrEq), .BrLT(BrLT), .BrUn(BrUn), .pc_if(pc_if),
    .fetch_valid(fetch_valid), .if_id_flush(if_id_flush), .misalign_exc(misalign_exc),
    .br_count(br_count), .br_taken_cnt(br_taken_cnt));

  branch_resolve_pc_unit #(.RESET_PC(RST_PC), .TRAP_VEC(TVEC), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .stall(stall), .id_valid(id_valid), .id_branch(id_branch),
    .id_jal(id_jal), .id_jalr(id_jalr), .id_funct3(id_funct3), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1_fwd(id_rs1_fwd), .BrEq(BrEq), .BrLT(BrLT), .BrUn(BrUn_s), .pc_if(pc_if_s),
    .fetch_valid(fetch_valid_s), .if_id_flush(if_id_flush_s), .misalign_exc(misalign_exc_s),
    .br_count(br_count_s), .br_taken_cnt(br_taken_cnt_s));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    stall = 0; id_valid = 0; id_branch = 0; id_jal = 0; id_jalr = 0; id_funct3 = 3'b000;
    id_pc = 0; id_imm = 0; id_rs1_fwd = 0; BrEq = 0; BrLT = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic vl, input logic [2:0] kind, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                       input logic eq, input logic lt);
    stall = st; id_valid = vl; id_branch = kind[0]; id_jal = kind[1]; id_jalr = kind[2];
    id_funct3 = f3; id_pc = pc; id_imm = imm; id_rs1_fwd = rs1; BrEq = eq; BrLT = lt;
  endtask

  // kind bits: [2]=jalr [1]=jal [0]=branch
  typedef struct {
    logic        st, vl;
    logic [2:0]  kind, f3;
    logic [31:0] pc, imm, rs1;
    logic        eq, lt;
    logic        e_flush, e_brun, e_redir;
    logic [31:0] e_tgt;
    logic        e_cnt, e_tk;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic vl, input logic [2:0] kind,
                              input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                              input logic [31:0] rs1, input logic eq, input logic lt,
                              input logic e_flush, input logic e_brun, input logic e_redir,
                              input logic [31:0] e_tgt, input logic e_cnt, input logic e_tk);
    vec_t v;
    v.st = st; v.vl = vl; v.kind = kind; v.f3 = f3; v.pc = pc; v.imm = imm; v.rs1 = rs1;
    v.eq = eq; v.lt = lt; v.e_flush = e_flush; v.e_brun = e_brun; v.e_redir = e_redir;
    v.e_tgt = e_tgt; v.e_cnt = e_cnt; v.e_tk = e_tk;
    return v;
  endfunction

  vec_t tbl[13];
  logic [31:0] exp_pc, exp_br, exp_tk;

  // reference model state
  localparam int M_BOOT = 0, M_RUN = 1, M_TRAP = 2;
  int          m_state;

  function automatic logic br_cond(input logic [2:0] f3, input logic eq, input logic lt);
    case (f3)
      3'd0: return eq;        // beq
      3'd1: return !eq;       // bne
      3'd4: return lt;        // blt
      3'd5: return !lt;       // bge
      3'd6: return lt;        // bltu
      3'd7: return !lt;       // bgeu
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    idle();
    rst_n = 0;
    #12;
    chk("rst_pc", pc_if, RST_PC);
    chk("rst_fetch_valid", {31'b0, fetch_valid}, 0);
    chk("rst_flush", {31'b0, if_id_flush}, 0);
    chk("rst_exc", {31'b0, misalign_exc}, 0);
    chk("rst_br_count", br_count, 0);
    tick();
    rst_n = 1;
    // a jump presented during BOOT must not flush
    drive(0, 1, 3'b010, 3'd0, 32'h40, 32'h20, 0, 0, 0);
    #2;
    chk("boot_fetch_valid", {31'b0, fetch_valid}, 0);
    chk("boot_flush", {31'b0, if_id_flush}, 0);
    chk("boot_exc", {31'b0, misalign_exc}, 0);
    chk("boot_pc", pc_if, RST_PC);
    idle();
    tick();
    chk("run_pc0", pc_if, 0);
    chk("run_fv0", {31'b0, fetch_valid}, 1);
    tick();
    chk("run_pc4", pc_if, 4);
    tick();
    chk("run_pc8", pc_if, 8);
    chk("run_fv8", {31'b0, fetch_valid}, 1);
    exp_pc = 8; exp_br = 0; exp_tk = 0;

    tbl[0]  = mk(0, 1, 3'b001, 3'd0, 32'h40, 32'h20, 0, 1, 0, 1, 0, 1, 32'h60, 1, 1);
    tbl[1]  = mk(0, 1, 3'b001, 3'd1, 32'h40, 32'h20, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    tbl[2]  = mk(0, 1, 3'b001, 3'd6, 32'h100, 32'hFFFF_FFF8, 0, 0, 1, 1, 1, 1, 32'hF8, 1, 1);
    tbl[3]  = mk(0, 1, 3'b001, 3'd4, 32'h100, 32'h10, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[4]  = mk(0, 1, 3'b001, 3'd5, 32'h100, 32'h10, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    tbl[5]  = mk(0, 1, 3'b001, 3'd7, 32'h200, 32'h40, 0, 0, 0, 1, 1, 1, 32'h240, 1, 1);
    tbl[6]  = mk(0, 1, 3'b001, 3'd2, 32'h200, 32'h40, 0, 1, 1, 0, 1, 0, 0, 1, 0);
    tbl[7]  = mk(0, 1, 3'b010, 3'd0, 32'h1000, 32'h10, 0, 0, 0, 1, 0, 1, 32'h1010, 0, 0);
    tbl[8]  = mk(0, 1, 3'b100, 3'd0, 32'h40, 32'h3, 32'h101, 0, 0, 1, 0, 1, 32'h104, 0, 0);
    tbl[9]  = mk(0, 1, 3'b110, 3'd0, 32'h40, 32'h4, 32'h200, 0, 0, 1, 0, 1, 32'h204, 0, 0);
    tbl[10] = mk(1, 1, 3'b001, 3'd0, 32'h40, 32'h20, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(0, 0, 3'b001, 3'd0, 32'h40, 32'h20, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 1, 3'b010, 3'd0, 32'hFFFF_FFF0, 32'h20, 0, 0, 0, 1, 0, 1, 32'h10, 0, 0);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].st, tbl[i].vl, tbl[i].kind, tbl[i].f3, tbl[i].pc, tbl[i].imm, tbl[i].rs1,
            tbl[i].eq, tbl[i].lt);
      #2;
      chk($sformatf("tbl%0d_flush", i), {31'b0, if_id_flush}, {31'b0, tbl[i].e_flush});
      chk($sformatf("tbl%0d_brun", i), {31'b0, BrUn}, {31'b0, tbl[i].e_brun});
      chk($sformatf("tbl%0d_exc", i), {31'b0, misalign_exc}, 0);
      tick();
      exp_pc = tbl[i].e_redir ? tbl[i].e_tgt : (tbl[i].st ? exp_pc : exp_pc + 4);
      exp_br += {31'b0, tbl[i].e_cnt};
      exp_tk += {31'b0, tbl[i].e_tk};
      chk($sformatf("tbl%0d_pc", i), pc_if, exp_pc);
      chk($sformatf("tbl%0d_br", i), br_count, exp_br);
      chk($sformatf("tbl%0d_tk", i), br_taken_cnt, exp_tk);
    end

    // misaligned JALR: pulse, TRAP cycle, then TRAP_VEC
    drive(0, 1, 3'b100, 3'd0, 32'h40, 32'h0, 32'h103, 0, 0);
    #2;
    chk("mis_exc", {31'b0, misalign_exc}, 1);
    chk("mis_flush", {31'b0, if_id_flush}, 1);
    tick();
    idle();
    #2;
    chk("trap_fv", {31'b0, fetch_valid}, 0);
    chk("trap_flush", {31'b0, if_id_flush}, 1);
    chk("trap_exc", {31'b0, misalign_exc}, 0);
    chk("trap_pc_held", pc_if, exp_pc);
    tick();
    chk("trap_vec", pc_if, TVEC);
    chk("trap_fv_after", {31'b0, fetch_valid}, 1);
    exp_pc = TVEC;

    // taken BEQ held by stall for two cycles
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 3'b001, 3'd0, 32'h80, 32'h40, 0, 1, 0);
      #2;
      chk("stall_flush", {31'b0, if_id_flush}, 0);
      tick();
      chk("stall_pc", pc_if, exp_pc);
      chk("stall_br", br_count, exp_br);
    end
    drive(0, 1, 3'b001, 3'd0, 32'h80, 32'h40, 0, 1, 0);
    #2;
    chk("unstall_flush", {31'b0, if_id_flush}, 1);
    tick();
    exp_br++; exp_tk++;
    chk("unstall_pc", pc_if, 32'hC0);
    chk("unstall_br", br_count, exp_br);
    chk("unstall_tk", br_taken_cnt, exp_tk);

    // sequential fetch wraps from the top of the address space
    drive(0, 1, 3'b010, 3'd0, 32'h0, 32'hFFFF_FFFC, 0, 0, 0);
    tick();
    chk("wrap_top", pc_if, 32'hFFFF_FFFC);
    idle();
    tick();
    chk("wrap_zero", pc_if, 0);

    // reset asserted while a redirect is pending
    drive(0, 1, 3'b001, 3'd0, 32'h40, 32'h20, 0, 1, 0);
    #2;
    chk("pre_rst_flush", {31'b0, if_id_flush}, 1);
    rst_n = 0;
    #1;
    chk("midrst_pc", pc_if, RST_PC);
    chk("midrst_flush", {31'b0, if_id_flush}, 0);
    chk("midrst_fv", {31'b0, fetch_valid}, 0);
    chk("midrst_br", br_count, 0);
    tick();
    chk("midrst_pc_hold", pc_if, RST_PC);
    rst_n = 1;
    #2;
    chk("reboot_flush", {31'b0, if_id_flush}, 0);
    tick();
    chk("reboot_pc", pc_if, RST_PC);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sat_pc", pc_if, 32'h60);
    end
    chk("sat_small_br", {30'b0, br_count_s}, 3);
    chk("sat_small_tk", {30'b0, br_taken_cnt_s}, 3);
    chk("sat_big_br", br_count, 4);
    chk("sat_big_tk", br_taken_cnt, 4);
    exp_pc = 32'h60; exp_br = 4; exp_tk = 4;
    m_state = M_RUN;

    // random stimulus against the reference model
    for (int n = 0; n < 400; n++) begin
      logic [2:0]  kind, f3;
      logic [31:0] pc, imm, rs1, tgt;
      logic        st, vl, eq, lt, resolve, tk, mis, e_flush, e_exc;
      int          r;
      st = ($urandom_range(0, 4) == 0);
      vl = ($urandom_range(0, 3) != 0);
      r  = $urandom_range(0, 8);
      kind = (r < 3) ? 3'b001 : (r < 5) ? 3'b010 : (r < 7) ? 3'b100 : (r == 7) ? 3'b110 : 3'b000;
      f3  = 3'($urandom_range(0, 7));
      pc  = $urandom() & 32'hFFFF_FFFC;
      imm = $urandom() & 32'hFFFF_FFFE;
      rs1 = $urandom();
      eq  = 1'($urandom_range(0, 1));
      lt  = 1'($urandom_range(0, 1));
      drive(st, vl, kind, f3, pc, imm, rs1, eq, lt);

      resolve = vl && !st && (m_state == M_RUN);
      tk  = resolve && (kind[2] || kind[1] || (kind[0] && br_cond(f3, eq, lt)));
      tgt = kind[2] ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
      mis = (tgt[1:0] != 2'b00);
      e_flush = (m_state == M_TRAP) || tk;
      e_exc   = tk && mis;
      #2;
      chk("rnd_flush", {31'b0, if_id_flush}, {31'b0, e_flush});
      chk("rnd_exc", {31'b0, misalign_exc}, {31'b0, e_exc});
      chk("rnd_brun", {31'b0, BrUn}, {31'b0, f3[1]});
      chk("rnd_fv", {31'b0, fetch_valid}, {31'b0, m_state == M_RUN});
      tick();
      if (resolve && kind[0]) begin
        if (exp_br != 32'hFFFF_FFFF) exp_br++;
        if (tk && exp_tk != 32'hFFFF_FFFF) exp_tk++;
      end
      if (m_state == M_TRAP) begin
        m_state = M_RUN;
        exp_pc  = TVEC;
      end else if (tk) begin
        if (mis) m_state = M_TRAP;
        else     exp_pc = tgt;
      end else if (!st) begin
        exp_pc = exp_pc + 4;
      end
      chk("rnd_pc", pc_if, exp_pc);
      chk("rnd_br", br_count, exp_br);
      chk("rnd_tk", br_taken_cnt, exp_tk);
      chk("rnd_small_br", {30'b0, br_count_s}, (exp_br > 3) ? 3 : exp_br);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
